// File: rtl/alu_serial.sv
// Bit-serial 32-bit ALU: one operand bit per clock, LSB first, through an IDLE/RUN/DONE FSM.
// Results and status flags are committed on the edge that processes the last bit.
module alu_serial (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        ty,
  input  logic [2:0]  ALU_op,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] res,
  output logic        zero,
  output logic        carry,
  output logic        overflow,
  output logic [1:0]  dbg_state
);

  // Handshake: an operation is accepted on a rising edge where ready=1 and start=1;
  // done is a single-cycle pulse and res/flags are valid from that cycle onward.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_RSV = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic        cy_q, cy_d;
  logic [31:0] sr_q, sr_d;
  logic [31:0] res_q, res_d;
  logic        zero_q, zero_d;
  logic        carry_q, carry_d;
  logic        ovf_q, ovf_d;

  logic        a_bit, b_bit, is_sub, is_arith;
  logic        sum_bit, cout, res_bit, ovf_bit;
  logic [31:0] final_res;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (count_q == 5'd31) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready     = (state_q == S_IDLE);
    busy      = (state_q == S_RUN);
    done      = (state_q == S_DONE);
    dbg_state = state_q;
  end

  // Subtraction is A + ~B + 1: invert B per bit and seed the carry with 1 at acceptance.
  always_comb begin
    a_bit    = a_q[count_q];
    b_bit    = b_q[count_q];
    is_sub   = (op_q == OP_SUB) || (op_q == OP_SLT);
    is_arith = is_sub || (op_q == OP_ADD);
    sum_bit  = a_bit ^ (b_bit ^ is_sub) ^ cy_q;
    cout     = (a_bit & (b_bit ^ is_sub)) | (a_bit & cy_q) | ((b_bit ^ is_sub) & cy_q);
    ovf_bit  = is_arith & (cy_q ^ cout);
    case (op_q)
      OP_AND:  res_bit = a_bit & b_bit;
      OP_OR:   res_bit = a_bit | b_bit;
      OP_ADD:  res_bit = sum_bit;
      OP_XOR:  res_bit = a_bit ^ b_bit;
      OP_NOR:  res_bit = ~(a_bit | b_bit);
      OP_SUB:  res_bit = sum_bit;
      OP_SLT:  res_bit = sum_bit;
      default: res_bit = 1'b0;
    endcase
  end

  always_comb begin
    count_d   = count_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    cy_d      = cy_q;
    sr_d      = sr_q;
    res_d     = res_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    final_res = 32'd0;
    if (state_q == S_IDLE && start) begin
      a_d     = A;
      b_d     = B & {32{ty}};
      op_d    = ALU_op;
      count_d = 5'd0;
      sr_d    = 32'd0;
      cy_d    = (ALU_op == OP_SUB) || (ALU_op == OP_SLT);
    end else if (state_q == S_RUN) begin
      sr_d    = {res_bit, sr_q[31:1]};
      cy_d    = cout;
      count_d = count_q + 5'd1;
      if (count_q == 5'd31) begin
        // On the last bit sum_bit is sum[31], so signed less-than is sum[31] ^ overflow.
        if (op_q == OP_SLT) final_res = {31'd0, sum_bit ^ ovf_bit};
        else                final_res = sr_d;
        res_d   = final_res;
        zero_d  = (final_res == 32'd0) && (op_q != OP_RSV);
        carry_d = is_arith & cout;
        ovf_d   = ovf_bit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 5'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= 3'd0;
      cy_q    <= 1'b0;
      sr_q    <= 32'd0;
      res_q   <= 32'd0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cy_q    <= cy_d;
      sr_q    <= sr_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign res      = res_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_alu_serial.sv
// Bench for alu_serial: directed vectors, random operations against an arithmetic reference
// model, mid-run operand/start disturbance, reset abort and back-to-back operation.
module tb_alu_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] A, B;
  logic        ty;
  logic [2:0]  ALU_op;
  logic        ready, busy, done;
  logic [31:0] res;
  logic        zero, carry, overflow;
  logic [1:0]  dbg_state;

  int compared = 0;
  int mismatched = 0;
  logic [34:0] exp_q[$];
  logic [34:0] last_exp;
  logic [34:0] obs;

  alu_serial dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .ty(ty), .ALU_op(ALU_op),
    .ready(ready), .busy(busy), .done(done), .res(res), .zero(zero), .carry(carry),
    .overflow(overflow), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Packed result word: {res, zero, carry, overflow}.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic t, input logic [2:0] op);
    logic [31:0] be, r;
    logic [32:0] s;
    logic        c, v;
    be = t ? b : 32'd0;
    r = 32'd0; c = 1'b0; v = 1'b0; s = 33'd0;
    case (op)
      3'b000: r = a & be;
      3'b001: r = a | be;
      3'b011: r = a ^ be;
      3'b100: r = ~(a | be);
      3'b010: begin
        s = {1'b0, a} + {1'b0, be};
        r = s[31:0]; c = s[32];
        v = (a[31] == be[31]) && (s[31] != a[31]);
      end
      3'b110, 3'b111: begin
        s = {1'b0, a} + {1'b0, ~be} + 33'd1;
        c = s[32];
        v = (a[31] != be[31]) && (s[31] != a[31]);
        r = (op == 3'b110) ? s[31:0] : {31'd0, ($signed(a) < $signed(be))};
      end
      default: return 35'd0;
    endcase
    return {r, (r == 32'd0), c, v};
  endfunction

  task automatic check(input string tag, input logic [34:0] observed, input logic [34:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation, disturbs inputs during RUN, checks latency, stability and result.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic t, input logic [2:0] op, output logic [34:0] o);
    logic [34:0] exp;
    int n;
    bit unstable;
    check({tag, "_ready_pre"}, 35'(ready), 35'd1);
    A = a; B = b; ty = t; ALU_op = op; start = 1'b1;
    exp_q.push_back(model(a, b, t, op));
    tick();
    start = 1'b0;
    A = $urandom; B = $urandom; ty = 1'($urandom_range(0, 1)); ALU_op = 3'($urandom_range(0, 7));
    n = 1;
    unstable = 1'b0;
    while (done !== 1'b1 && n < 40) begin
      if ({res, zero, carry, overflow} !== last_exp || busy !== 1'b1 || ready !== 1'b0) unstable = 1'b1;
      start = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 35'(n), 35'd33);
    check({tag, "_run_stable"}, 35'(unstable), 35'd0);
    o = {res, zero, carry, overflow};
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 35'd0;
    check({tag, "_result"}, o, exp);
    last_exp = exp;
    tick();
    check({tag, "_ready_post"}, {33'd0, ready, done}, 35'b10);
  endtask

  initial begin
    int n;
    bit saw_done;
    logic [34:0] e1, e2;
    rst = 1'b1; start = 1'b0; A = 32'd0; B = 32'd0; ty = 1'b0; ALU_op = 3'd0;
    last_exp = 35'd0;
    repeat (3) tick();
    rst = 1'b0;
    check("reset_ctrl", {32'd0, ready, busy, done}, 35'b100);
    check("reset_res", {res, zero, carry, overflow}, 35'd0);
    check("reset_state", 35'(dbg_state), 35'd0);

    run_op("add_wrap", 32'hFFFF_FFFF, 32'h1, 1'b1, 3'b010, obs);
    check("add_wrap_const", obs, {32'h0, 3'b110});
    run_op("sub_5_7", 32'd5, 32'd7, 1'b1, 3'b110, obs);
    check("sub_5_7_const", obs, {32'hFFFF_FFFE, 3'b000});
    run_op("add_ovf", 32'h7FFF_FFFF, 32'h1, 1'b1, 3'b010, obs);
    check("add_ovf_const", obs, {32'h8000_0000, 3'b001});
    run_op("slt_neg", 32'h8000_0000, 32'h1, 1'b1, 3'b111, obs);
    check("slt_neg_const", obs, {32'h1, 3'b011});
    run_op("slt_pos", 32'h1, 32'h8000_0000, 1'b1, 3'b111, obs);
    check("slt_pos_const", obs, {32'h0, 3'b101});
    run_op("ty_or", 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 3'b001, obs);
    check("ty_or_const", obs, {32'h1234_5678, 3'b000});
    run_op("ty_and", 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 3'b000, obs);
    check("ty_and_const", obs, {32'h0, 3'b100});
    run_op("rsv", 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 3'b101, obs);
    check("rsv_const", obs, 35'd0);
    run_op("nor_zero", 32'hFFFF_FFFF, 32'h0, 1'b1, 3'b100, obs);
    run_op("xor_self", 32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b1, 3'b011, obs);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (i % 4 == 0) ? ra : $urandom;
      run_op("rand", ra, rb, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), obs);
    end

    // Abort with reset after ten bits have been processed.
    A = 32'd100; B = 32'd200; ty = 1'b1; ALU_op = 3'b010; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_ctrl", {32'd0, ready, busy, done}, 35'b100);
    check("abort_res", {res, zero, carry, overflow}, 35'd0);
    saw_done = 1'b0;
    repeat (40) begin
      if (done === 1'b1) saw_done = 1'b1;
      tick();
    end
    check("abort_no_done", 35'(saw_done), 35'd0);
    last_exp = 35'd0;

    run_op("add_3_4", 32'd3, 32'd4, 1'b1, 3'b010, obs);
    check("add_3_4_const", obs, {32'd7, 3'b000});

    // Back-to-back: start held high across the ready cycle.
    e1 = model(32'h0000_1000, 32'h0000_0234, 1'b1, 3'b110);
    e2 = model(32'hDEAD_BEEF, 32'h1111_1111, 1'b1, 3'b001);
    A = 32'h0000_1000; B = 32'h0000_0234; ty = 1'b1; ALU_op = 3'b110; start = 1'b1;
    tick();
    A = 32'hDEAD_BEEF; B = 32'h1111_1111; ALU_op = 3'b001;
    n = 1;
    while (done !== 1'b1 && n < 40) begin tick(); n++; end
    check("b2b_lat1", 35'(n), 35'd33);
    check("b2b_res1", {res, zero, carry, overflow}, e1);
    tick();
    check("b2b_ready", {33'd0, ready, start}, 35'b11);
    tick();
    start = 1'b0;
    check("b2b_accept", {33'd0, busy, ready}, 35'b10);
    n = 2;
    while (done !== 1'b1 && n < 40) begin tick(); n++; end
    check("b2b_period", 35'(n), 35'd34);
    check("b2b_res2", {res, zero, carry, overflow}, e2);
    tick();
    check("b2b_idle", {32'd0, ready, busy, done}, 35'b100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
